alu_pipe: RTL



---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_clamp.sv | 24 ++
 rtl/alu_pipe.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   OP_W      : width of the op field, shared with the legacy ALU decode
//   op_t      : op field type
//   OP_*      : op encodings (zero / add / mul / mac)
package alu_pkg;

    localparam int OP_W = 2;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_ZERO = 2'b00;
    localparam op_t OP_ADD  = 2'b01;
    localparam op_t OP_MUL  = 2'b10;
    localparam op_t OP_MAC  = 2'b11;

endpackage

// File: rtl/alu_clamp.sv
// alu_clamp: reduces a full-width arithmetic value to WIDTH bits.
//   full_val : untruncated value (2*WIDTH+1 bits)
//   ovf      : overflow indication for full_val
//   val      : low WIDTH bits, or all-ones when SATURATE=1 and ovf=1
module alu_clamp #(
    parameter int WIDTH    = 16,
    parameter int SATURATE = 0
) (
    input  logic [2*WIDTH:0]  full_val,
    input  logic              ovf,
    output logic [WIDTH-1:0]  val
);

    // Wrap by truncation, or clamp to all-ones on overflow when saturating.
    always_comb begin
        val = full_val[WIDTH-1:0];
        if ((SATURATE != 0) && ovf) begin
            val = {WIDTH{1'b1}};
        end else begin
            val = full_val[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined add / mul / multiply-accumulate ALU with valid/ready.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid, in_ready : operand handshake (in_ready = pipeline enable)
//   a, b               : unsigned operands
//   op                 : 00 zero, 01 add, 10 mul, 11 mac
//   acc_clr            : with mac, accumulate from 0 instead of acc
//   out_valid,out_ready: result handshake
//   result, ovf        : registered result and its overflow flag
// Register layers: operand capture (S1), S1 sum/product capture, then the S2
// result/acc registers, giving two edges from acceptance to out_valid.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic               en_s;

    logic               s1_valid_r;
    logic [WIDTH-1:0]   s1_a_r;
    logic [WIDTH-1:0]   s1_b_r;
    op_t                s1_op_r;
    logic               s1_clr_r;
    logic [WIDTH:0]     s1_sum_s;
    logic [2*WIDTH-1:0] s1_prod_s;

    logic               s2_valid_r;
    logic [WIDTH:0]     s2_sum_r;
    logic [2*WIDTH-1:0] s2_prod_r;
    op_t                s2_op_r;
    logic               s2_clr_r;

    logic [2*WIDTH:0]   s2_full_s;
    logic               s2_ovf_s;
    logic [WIDTH-1:0]   s2_acc_base_s;
    logic [WIDTH-1:0]   s2_clamp_s;

    logic               out_valid_r;
    logic [WIDTH-1:0]   result_r;
    logic               ovf_r;
    logic [WIDTH-1:0]   acc_r;

    // Whole pipeline stalls only when a result is waiting and not taken.
    always_comb begin
        en_s = !(out_valid_r && !out_ready);
    end

    assign in_ready  = en_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign ovf       = ovf_r;

    // Full-precision sum and product of the registered operands.
    always_comb begin
        s1_sum_s  = {1'b0, s1_a_r} + {1'b0, s1_b_r};
        s1_prod_s = {{WIDTH{1'b0}}, s1_a_r} * {{WIDTH{1'b0}}, s1_b_r};
    end

    // S1 operand capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_op_r    <= OP_ZERO;
            s1_clr_r   <= 1'b0;
        end else if (en_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_a_r   <= a;
                s1_b_r   <= b;
                s1_op_r  <= op_t'(op);
                s1_clr_r <= acc_clr;
            end
        end
    end

    // S1 sum/product capture feeding S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_sum_r   <= {(WIDTH+1){1'b0}};
            s2_prod_r  <= {(2*WIDTH){1'b0}};
            s2_op_r    <= OP_ZERO;
            s2_clr_r   <= 1'b0;
        end else if (en_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_sum_r  <= s1_sum_s;
                s2_prod_r <= s1_prod_s;
                s2_op_r   <= s1_op_r;
                s2_clr_r  <= s1_clr_r;
            end
        end
    end

    // Select the full-width value and its overflow per op; acc is read here only.
    always_comb begin
        s2_full_s     = {(2*WIDTH+1){1'b0}};
        s2_ovf_s      = 1'b0;
        s2_acc_base_s = s2_clr_r ? {WIDTH{1'b0}} : acc_r;
        case (s2_op_r)
            OP_ZERO: begin
                s2_full_s = {(2*WIDTH+1){1'b0}};
                s2_ovf_s  = 1'b0;
            end
            OP_ADD: begin
                s2_full_s = {{WIDTH{1'b0}}, s2_sum_r};
                s2_ovf_s  = s2_sum_r[WIDTH];
            end
            OP_MUL: begin
                s2_full_s = {1'b0, s2_prod_r};
                s2_ovf_s  = |s2_prod_r[2*WIDTH-1:WIDTH];
            end
            OP_MAC: begin
                s2_full_s = {{(WIDTH+1){1'b0}}, s2_acc_base_s} + {1'b0, s2_prod_r};
                s2_ovf_s  = |s2_full_s[2*WIDTH:WIDTH];
            end
            default: begin
                s2_full_s = {(2*WIDTH+1){1'b0}};
                s2_ovf_s  = 1'b0;
            end
        endcase
    end

    alu_clamp #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_clamp (
        .full_val (s2_full_s),
        .ovf      (s2_ovf_s),
        .val      (s2_clamp_s)
    );

    // S2 result, flag and accumulator registers; bubbles never touch acc.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            ovf_r       <= 1'b0;
            acc_r       <= {WIDTH{1'b0}};
        end else if (en_s) begin
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                result_r <= s2_clamp_s;
                ovf_r    <= s2_ovf_s;
                if (s2_op_r == OP_MAC) begin
                    acc_r <= s2_clamp_s;
                end
            end
        end
    end

endmodule
